// File: rtl/hm2_pinmux_pkg.sv
// Shared types and board geometry for the hostmot2 GPIO pin-mux sequencer.
// Word count and CTRL address are derived from the pin count.
package hm2_pinmux_pkg;

  localparam int BOARD_IO_PORTS   = 3;
  localparam int BOARD_PORT_WIDTH = 24;
  localparam int BOARD_IO_WIDTH   = BOARD_IO_PORTS * BOARD_PORT_WIDTH;

  typedef enum logic [1:0] {
    MODE_IN  = 2'd0,
    MODE_HM2 = 2'd1,
    MODE_LO  = 2'd2,
    MODE_HI  = 2'd3
  } pin_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARK,
    ST_SETTLE,
    ST_LOAD,
    ST_FINISH
  } seq_state_t;

  // Two mode bits per pin, packed into bus-width words; CTRL sits right after.
  function automatic int calc_nwords(input int io_width, input int bus_width);
    return (2 * io_width + bus_width - 1) / bus_width;
  endfunction

  function automatic int calc_ctrl_addr(input int io_width, input int bus_width);
    return calc_nwords(io_width, bus_width);
  endfunction

endpackage

// File: rtl/pinmux_shadow_regs.sv
// Shadow mode storage with registered readback; writes arriving while a
// sequence runs are dropped and flagged with a one-cycle reject pulse.
module pinmux_shadow_regs
  import hm2_pinmux_pkg::*;
#(
  parameter int IOWidth   = BOARD_IO_WIDTH,
  parameter int BusWidth  = 32,
  parameter int AddrWidth = 4,
  parameter int NWords    = calc_nwords(IOWidth, BusWidth)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 bus_wr_i,
  input  logic                 bus_rd_i,
  input  logic [AddrWidth-1:0] bus_addr_i,
  input  logic [BusWidth-1:0]  bus_wdata_i,
  input  logic                 busy_i,
  input  logic                 pending_i,
  input  logic [7:0]           port_idx_i,
  output logic [BusWidth-1:0]  bus_rdata_o,
  output logic                 wr_reject_o,
  output logic                 commit_o,
  output logic [2*IOWidth-1:0] shadow_o
);

  localparam int WIDX = (NWords > 1) ? $clog2(NWords) : 1;
  localparam logic [AddrWidth-1:0] CTRL_ADDR = AddrWidth'(calc_ctrl_addr(IOWidth, BusWidth));

  logic [BusWidth-1:0] shadow_q [NWords];
  logic [BusWidth-1:0] rdata_q;
  logic                reject_q;
  logic [WIDX-1:0]     word_idx;
  logic                is_word;
  logic                is_ctrl;
  logic [BusWidth-1:0] wmask;
  logic [BusWidth-1:0] ctrl_word;

  assign word_idx = bus_addr_i[WIDX-1:0];
  assign is_word  = bus_addr_i < CTRL_ADDR;
  assign is_ctrl  = bus_addr_i == CTRL_ADDR;
  assign commit_o = bus_wr_i && is_ctrl && bus_wdata_i[0];

  // Bits beyond the last pin never store anything, so they read back as 0.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < BusWidth; b++) begin
      wmask[b] = (int'(word_idx) * BusWidth + b) < 2 * IOWidth;
    end
    ctrl_word       = '0;
    ctrl_word[0]    = busy_i;
    ctrl_word[1]    = pending_i;
    ctrl_word[15:8] = port_idx_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int w = 0; w < NWords; w++) shadow_q[w] <= '0;
      rdata_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= bus_wr_i && is_word && busy_i;
      if (bus_wr_i && is_word && !busy_i) shadow_q[word_idx] <= bus_wdata_i & wmask;
      if (bus_rd_i) rdata_q <= is_word ? shadow_q[word_idx] : (is_ctrl ? ctrl_word : '0);
    end
  end

  always_comb begin
    shadow_o = '0;
    for (int i = 0; i < IOWidth; i++) begin
      shadow_o[2*i +: 2] = shadow_q[WIDX'((2 * i) / BusWidth)][(2 * i) % BusWidth +: 2];
    end
  end

  assign bus_rdata_o = rdata_q;
  assign wr_reject_o = reject_q;

endmodule

// File: rtl/gpio_pinmux_sequencer.sv
// Applies committed shadow pin modes port by port: park hi-Z, settle, load.
// A commit during a sequence is remembered and relaunches straight from FINISH.
module gpio_pinmux_sequencer
  import hm2_pinmux_pkg::*;
#(
  parameter int IOPorts      = BOARD_IO_PORTS,
  parameter int PortWidth    = BOARD_PORT_WIDTH,
  parameter int IOWidth      = BOARD_IO_WIDTH,
  parameter int BusWidth     = 32,
  parameter int AddrWidth    = 4,
  parameter int SettleCycles = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bus_wr,
  input  logic                 bus_rd,
  input  logic [AddrWidth-1:0] bus_addr,
  input  logic [BusWidth-1:0]  bus_wdata,
  output logic [BusWidth-1:0]  bus_rdata,
  output logic [2*IOWidth-1:0] active_mode,
  output logic [IOPorts-1:0]   port_parked,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_reject
);

  localparam int NWords = calc_nwords(IOWidth, BusWidth);
  localparam int PW     = (IOPorts > 1) ? $clog2(IOPorts) : 1;
  localparam int PSW    = 2 * PortWidth;
  localparam logic [PW-1:0] LAST_PORT   = PW'(IOPorts - 1);
  localparam logic [7:0]    SETTLE_INIT = 8'(SettleCycles - 1);

  seq_state_t           state_q, state_d;
  logic [PW-1:0]        port_q, port_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [2*IOWidth-1:0] mode_q;
  logic [IOPorts-1:0]   parked_q;
  logic                 commit;
  logic [2*IOWidth-1:0] shadow;

  pinmux_shadow_regs #(
    .IOWidth  (IOWidth),
    .BusWidth (BusWidth),
    .AddrWidth(AddrWidth),
    .NWords   (NWords)
  ) u_shadow (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .bus_wr_i   (bus_wr),
    .bus_rd_i   (bus_rd),
    .bus_addr_i (bus_addr),
    .bus_wdata_i(bus_wdata),
    .busy_i     (busy),
    .pending_i  (pending_q),
    .port_idx_i (8'(port_q)),
    .bus_rdata_o(bus_rdata),
    .wr_reject_o(wr_reject),
    .commit_o   (commit),
    .shadow_o   (shadow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      port_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | commit;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (commit || pending_q) begin
          state_d   = ST_PARK;
          port_d    = '0;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PARK: begin
        cnt_d   = SETTLE_INIT;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) state_d = ST_LOAD;
        else cnt_d = cnt_q - 8'd1;
      end
      ST_LOAD: begin
        if (port_q == LAST_PORT) begin
          state_d = ST_FINISH;
        end else begin
          port_d  = port_q + 1'b1;
          state_d = ST_PARK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_PARK, ST_SETTLE, ST_LOAD: busy = 1'b1;
      ST_FINISH:                   done = 1'b1;
      default: ;
    endcase
  end

  // Every port passes through hi-Z before taking new modes, so no driven-to-driven glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= '0;
      parked_q <= '1;
    end else begin
      for (int i = 0; i < IOPorts; i++) begin
        if (port_q == PW'(i)) begin
          if (state_q == ST_PARK) begin
            parked_q[i]          <= 1'b1;
            mode_q[i*PSW +: PSW] <= {PortWidth{MODE_IN}};
          end else if (state_q == ST_LOAD) begin
            parked_q[i]          <= 1'b0;
            mode_q[i*PSW +: PSW] <= shadow[i*PSW +: PSW];
          end
        end
      end
    end
  end

  assign active_mode = mode_q;
  assign port_parked = parked_q;

endmodule

// File: tb/tb_gpio_pinmux_sequencer.sv
// Directed + randomized bench for the pin-mux sequencer; a second instance
// with a one-cycle settle interval checks the shortened latency.
module tb_gpio_pinmux_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         bus_wr, bus_rd;
  logic [3:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic [31:0]  rdata0, rdata1;
  logic [143:0] mode0, mode1;
  logic [2:0]   parked0, parked1;
  logic         busy0, busy1, done0, done1, rej0, rej1;

  int checks;
  int errors;
  logic [31:0] m_sh [5];

  always #5 clk = ~clk;

  gpio_pinmux_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata0),
    .active_mode(mode0), .port_parked(parked0), .busy(busy0), .done(done0),
    .wr_reject(rej0)
  );

  gpio_pinmux_sequencer #(.SettleCycles(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata1),
    .active_mode(mode1), .port_parked(parked1), .busy(busy1), .done(done1),
    .wr_reject(rej1)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_wr = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_rd = 1'b1; bus_addr = a;
    tick();
    bus_rd = 1'b0;
    d = rdata0;
  endtask

  // 72 pins x 2 bits = 144 valid bits; word w covers bits 32w..32w+31.
  function automatic logic [31:0] word_mask(input int w);
    int valid;
    valid = 144 - 32 * w;
    if (valid >= 32) return 32'hFFFF_FFFF;
    if (valid <= 0) return 32'h0;
    return (32'h1 << valid) - 32'h1;
  endfunction

  task automatic shadow_wr(input int a, input logic [31:0] d);
    bus_write(4'(a), d);
    m_sh[a] = d & word_mask(a);
  endtask

  function automatic logic [143:0] model_modes();
    logic [143:0] r;
    logic [31:0]  w;
    for (int pin = 0; pin < 72; pin++) begin
      w = m_sh[pin / 16];
      r[2*pin +: 2] = w[2*(pin % 16) +: 2];
    end
    return r;
  endfunction

  task automatic commit_and_time(output int lat0, output int lat1);
    lat0 = -1; lat1 = -1;
    bus_write(4'd5, 32'h1);
    for (int n = 1; n <= 40; n++) begin
      if (done0 && lat0 < 0) lat0 = n;
      if (done1 && lat1 < 0) lat1 = n;
      if (lat0 >= 0 && lat1 >= 0) break;
      tick();
    end
  endtask

  initial begin
    logic [31:0] r;
    int lat0, lat1, t0, t1, viol, found, k2, extra;
    checks = 0; errors = 0;
    reset_n = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = '0; bus_wdata = '0;
    for (int w = 0; w < 5; w++) m_sh[w] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", 160'(mode0), 160'd0);
    chk("rst_parked", 160'(parked0), 160'd7);
    chk("rst_busy", 160'(busy0), 160'd0);
    chk("rst_done", 160'(done0), 160'd0);
    chk("rst_reject", 160'(rej0), 160'd0);
    chk("rst_rdata", 160'(rdata0), 160'd0);
    reset_n = 1'b1;
    tick();

    // Word0 all mode 1, then commit: latency on both settle settings.
    shadow_wr(0, 32'h5555_5555);
    commit_and_time(lat0, lat1);
    chk("lat_settle4", 160'(lat0), 160'd19);
    chk("lat_settle1", 160'(lat1), 160'd10);
    chk("t1_mode_const", 160'(mode0), 160'h5555_5555);
    chk("t1_mode_model", 160'(mode0), 160'(model_modes()));
    chk("t1_parked", 160'(parked0), 160'd0);
    chk("t1_mode_dut1", 160'(mode1), 160'(model_modes()));
    tick();

    // Masking of the partial last word and an unmapped address.
    shadow_wr(4, 32'hFFFF_FFFF);
    bus_read(4'd4, r);
    chk("word4_mask", 160'(r), 160'h0000_FFFF);
    bus_write(4'd7, 32'hDEAD_BEEF);
    bus_read(4'd7, r);
    chk("addr7_read", 160'(r), 160'd0);
    bus_read(4'd5, r);
    chk("ctrl_idle", 160'(r[1:0]), 160'd0);

    // Random shadows; watch parking order and hi-Z of the parked port.
    for (int w = 0; w < 5; w++) shadow_wr(w, $urandom);
    bus_write(4'd5, 32'h1);
    chk("busy_next_cycle", 160'(busy0), 160'd1);
    t0 = -1; t1 = -1; viol = 0; found = 0;
    for (int n = 1; n <= 40; n++) begin
      if ($countones(parked0) > 1) viol++;
      for (int p = 0; p < 3; p++)
        if (parked0[p] && mode0[p*48 +: 48] != 48'd0) viol++;
      if (parked0[0] && t0 < 0) t0 = n;
      if (parked0[1] && t1 < 0) t1 = n;
      if (done0) begin found = 1; break; end
      tick();
    end
    chk("seq_done_seen", 160'(found), 160'd1);
    chk("park_spacing", 160'(t1 - t0), 160'd6);
    chk("park_violations", 160'(viol), 160'd0);
    chk("rand_mode", 160'(mode0), 160'(model_modes()));
    chk("rand_parked", 160'(parked0), 160'd0);
    tick();

    // Writes and commits while busy.
    bus_write(4'd5, 32'h1);
    repeat (3) tick();
    bus_write(4'd2, $urandom);
    chk("reject_pulse", 160'(rej0), 160'd1);
    tick();
    chk("reject_single", 160'(rej0), 160'd0);
    bus_write(4'd5, 32'h1);
    bus_write(4'd5, 32'h1);
    bus_read(4'd5, r);
    chk("ctrl_pending_busy", 160'(r[1:0]), 160'd3);
    bus_read(4'd2, r);
    chk("word2_unchanged", 160'(r), 160'(m_sh[2]));
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (done0) begin found = 1; break; end
      tick();
    end
    chk("first_done", 160'(found), 160'd1);
    k2 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done0) begin k2 = k; break; end
    end
    chk("second_done_gap", 160'(k2), 160'd19);
    chk("pending_mode", 160'(mode0), 160'(model_modes()));
    extra = 0;
    repeat (30) begin
      tick();
      if (done0) extra++;
    end
    chk("commits_collapse", 160'(extra), 160'd0);
    chk("idle_busy", 160'(busy0), 160'd0);

    // Asynchronous reset in the middle of port1's settle interval.
    bus_write(4'd5, 32'h1);
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (parked0[1]) begin found = 1; break; end
      tick();
    end
    chk("port1_parked", 160'(found), 160'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_mode", 160'(mode0), 160'd0);
    chk("arst_busy", 160'(busy0), 160'd0);
    chk("arst_parked", 160'(parked0), 160'd7);
    for (int w = 0; w < 5; w++) m_sh[w] = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    bus_read(4'd0, r);
    chk("arst_shadow", 160'(r), 160'd0);

    // Random modes again on both instances.
    for (int w = 0; w < 5; w++) shadow_wr(w, $urandom);
    commit_and_time(lat0, lat1);
    chk("lat2_settle4", 160'(lat0), 160'd19);
    chk("lat2_settle1", 160'(lat1), 160'd10);
    chk("final_mode0", 160'(mode0), 160'(model_modes()));
    chk("final_mode1", 160'(mode1), 160'(model_modes()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
